result_monitor: RTL

Checking end of the arithmetic testbench. It takes the operand pairs that the operand driver holds back one cycle, plus the DUT's result bus, and lines each pair up with its result across the DUT's fixed pipeline latency. It computes the expected value with an internal reference model and compares it against the DUT result. It counts passes and failures for a bounded run and captures the first failing vector for debug.

---
 rtl/result_monitor.sv | 203 ++++++++++++++++++++
 1 files changed

// File: rtl/result_monitor.sv
// result_monitor: lines delayed operand pairs up with DUT results across the
// DUT pipeline latency, checks them against a reference model, and keeps
// pass/fail counts plus a snapshot of the first failing vector of each run.
module result_monitor #(
    parameter int WIDTH   = 32,
    parameter int LATENCY = 1,   // 1..16
    parameter int OP      = 0    // 0 add, 1 sub, 2 low-half mul; others act as add
) (
    input  logic             clk_dut,
    input  logic             reset_dut,
    input  logic             i_start,
    input  logic [31:0]      i_num_vectors,
    input  logic [WIDTH-1:0] i_delayed_a,
    input  logic [WIDTH-1:0] i_delayed_b,
    input  logic [WIDTH-1:0] i_dut_result,
    output logic             o_busy,
    output logic             o_done,
    output logic             o_mismatch,
    output logic [31:0]      o_pass_count,
    output logic [31:0]      o_fail_count,
    output logic [WIDTH-1:0] o_first_fail_a,
    output logic [WIDTH-1:0] o_first_fail_b,
    output logic [WIDTH-1:0] o_first_fail_exp,
    output logic [WIDTH-1:0] o_first_fail_got
);

    typedef enum logic [1:0] {S_IDLE, S_INJECT, S_DRAIN, S_DONE} state_e;

    state_e state_q, state_d;
    logic [31:0] remain_q, remain_d;
    logic        clear;      // accepted start: wipe results of the previous run
    logic        inject;     // current i_delayed_* pair belongs to the run

    logic             cmp_vld;
    logic [WIDTH-1:0] cmp_a, cmp_b;
    logic             upstream_vld;  // a valid tag still sits before the pipe output

    logic [31:0]      pass_q, pass_d, fail_q, fail_d;
    logic             mismatch_q, mismatch_d;
    logic             ff_flag_q, ff_flag_d;
    logic [WIDTH-1:0] ffa_q, ffa_d, ffb_q, ffb_d, ffe_q, ffe_d, ffg_q, ffg_d;
    logic [WIDTH-1:0] expected;

    // Reference model; all arithmetic wraps at WIDTH bits.
    function automatic logic [WIDTH-1:0] ref_model(input logic [WIDTH-1:0] a,
                                                   input logic [WIDTH-1:0] b);
        case (OP)
            1:       return a - b;
            2:       return a * b;
            default: return a + b;
        endcase
    endfunction

    assign inject = (state_q == S_INJECT);

    generate
        if (LATENCY == 1) begin : g_nopipe
            // Delayed operands already line up with the result.
            assign cmp_vld      = inject;
            assign cmp_a        = i_delayed_a;
            assign cmp_b        = i_delayed_b;
            assign upstream_vld = 1'b0;
        end else begin : g_pipe
            localparam int D = LATENCY - 1;
            logic [D-1:0]            vld_q;
            logic [D-1:0][WIDTH-1:0] a_q, b_q;

            // Alignment pipe: shifts {valid, a, b} one stage per cycle.
            always_ff @(posedge clk_dut or posedge reset_dut) begin
                if (reset_dut) begin
                    vld_q <= '0;
                    a_q   <= '0;
                    b_q   <= '0;
                end else begin
                    vld_q[0] <= inject;
                    a_q[0]   <= i_delayed_a;
                    b_q[0]   <= i_delayed_b;
                    for (int i = 1; i < D; i++) begin
                        vld_q[i] <= vld_q[i-1];
                        a_q[i]   <= a_q[i-1];
                        b_q[i]   <= b_q[i-1];
                    end
                end
            end

            // Any valid tag not yet at the output stage keeps the drain going.
            always_comb begin
                upstream_vld = 1'b0;
                for (int i = 0; i < D - 1; i++) upstream_vld = upstream_vld | vld_q[i];
            end

            assign cmp_vld = vld_q[D-1];
            assign cmp_a   = a_q[D-1];
            assign cmp_b   = b_q[D-1];
        end
    endgenerate

    // State and remaining-vector counter.
    always_ff @(posedge clk_dut or posedge reset_dut) begin
        if (reset_dut) begin
            state_q  <= S_IDLE;
            remain_q <= '0;
        end else begin
            state_q  <= state_d;
            remain_q <= remain_d;
        end
    end

    // Next-state logic; a start is only accepted when no run is in flight.
    always_comb begin
        state_d  = state_q;
        remain_d = remain_q;
        clear    = 1'b0;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (i_start) begin
                    clear    = 1'b1;
                    remain_d = i_num_vectors;
                    state_d  = (i_num_vectors != 32'd0) ? S_INJECT : S_DONE;
                end
            end
            S_INJECT: begin
                remain_d = remain_q - 32'd1;
                if (remain_q == 32'd1) state_d = (LATENCY == 1) ? S_DONE : S_DRAIN;
            end
            S_DRAIN: begin
                if (cmp_vld && !upstream_vld) state_d = S_DONE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign expected = ref_model(cmp_a, cmp_b);

    // Compare result: saturating counters, mismatch pulse, first-fail capture.
    always_comb begin
        pass_d     = pass_q;
        fail_d     = fail_q;
        mismatch_d = 1'b0;
        ff_flag_d  = ff_flag_q;
        ffa_d      = ffa_q;
        ffb_d      = ffb_q;
        ffe_d      = ffe_q;
        ffg_d      = ffg_q;
        if (clear) begin
            pass_d    = '0;
            fail_d    = '0;
            ff_flag_d = 1'b0;
            ffa_d     = '0;
            ffb_d     = '0;
            ffe_d     = '0;
            ffg_d     = '0;
        end else if (cmp_vld) begin
            if (expected == i_dut_result) begin
                if (pass_q != '1) pass_d = pass_q + 32'd1;
            end else begin
                mismatch_d = 1'b1;
                if (fail_q != '1) fail_d = fail_q + 32'd1;
                if (!ff_flag_q) begin
                    ff_flag_d = 1'b1;
                    ffa_d     = cmp_a;
                    ffb_d     = cmp_b;
                    ffe_d     = expected;
                    ffg_d     = i_dut_result;
                end
            end
        end
    end

    // Result registers.
    always_ff @(posedge clk_dut or posedge reset_dut) begin
        if (reset_dut) begin
            pass_q     <= '0;
            fail_q     <= '0;
            mismatch_q <= 1'b0;
            ff_flag_q  <= 1'b0;
            ffa_q      <= '0;
            ffb_q      <= '0;
            ffe_q      <= '0;
            ffg_q      <= '0;
        end else begin
            pass_q     <= pass_d;
            fail_q     <= fail_d;
            mismatch_q <= mismatch_d;
            ff_flag_q  <= ff_flag_d;
            ffa_q      <= ffa_d;
            ffb_q      <= ffb_d;
            ffe_q      <= ffe_d;
            ffg_q      <= ffg_d;
        end
    end

    assign o_busy           = (state_q == S_INJECT) || (state_q == S_DRAIN);
    assign o_done           = (state_q == S_DONE);
    assign o_mismatch       = mismatch_q;
    assign o_pass_count     = pass_q;
    assign o_fail_count     = fail_q;
    assign o_first_fail_a   = ffa_q;
    assign o_first_fail_b   = ffb_q;
    assign o_first_fail_exp = ffe_q;
    assign o_first_fail_got = ffg_q;

endmodule
